// File: rtl/alu_pkg.sv
// Shared definitions for the switch/button ALU: opcodes, display source select
// and the hex-to-seven-segment glyph table.
package alu_pkg;

    localparam logic [2:0] OP_CLR = 3'd0;
    localparam logic [2:0] OP_ADD = 3'd1;
    localparam logic [2:0] OP_SUB = 3'd2;
    localparam logic [2:0] OP_AND = 3'd3;
    localparam logic [2:0] OP_OR  = 3'd4;
    localparam logic [2:0] OP_XOR = 3'd5;
    localparam logic [2:0] OP_SHL = 3'd6;
    localparam logic [2:0] OP_SHR = 3'd7;

    typedef enum logic [1:0] {
        SHOW_A   = 2'd0,
        SHOW_B   = 2'd1,
        SHOW_RES = 2'd2
    } disp_sel_e;

    // Active-low segments, bit order {g,f,e,d,c,b,a}; b and d are lowercase glyphs.
    function automatic logic [6:0] hex2seg(input logic [3:0] n);
        logic [6:0] s;
        case (n)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            default: s = 7'h0E;
        endcase
        return s;
    endfunction

endpackage

// File: rtl/alu_top_param_pb_debounce.sv
// Push-button conditioner: 2-FF synchroniser, counting debouncer and a one-cycle
// strobe on the accepted rising level.
module pb_debounce #(
    parameter int DEBOUNCE_CYCLES = 16
) (
    input  logic i_clk,
    input  logic i_reset,
    input  logic i_raw,
    output logic o_strobe
);
    localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);

    logic          r_s1, r_s2, r_db, r_stb;
    logic [CW-1:0] r_cnt;

    // The accepted level flips on the DEBOUNCE_CYCLES-th consecutive mismatch;
    // the strobe is registered alongside that flip so it lines up with it.
    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_s1  <= 1'b0;
            r_s2  <= 1'b0;
            r_db  <= 1'b0;
            r_stb <= 1'b0;
            r_cnt <= '0;
        end else begin
            r_s1  <= i_raw;
            r_s2  <= r_s1;
            r_stb <= 1'b0;
            if (r_s2 == r_db) begin
                r_cnt <= '0;
            end else if (r_cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
                r_db  <= r_s2;
                r_cnt <= '0;
                r_stb <= r_s2;
            end else begin
                r_cnt <= r_cnt + 1'b1;
            end
        end
    end

    assign o_strobe = r_stb;

endmodule

// File: rtl/alu_top_param.sv
// Button/switch driven ALU: load A, B, execute an opcode, show A/B/result in hex
// on a multiplexed seven-segment display.
module alu_top_param
    import alu_pkg::*;
#(
    parameter int WIDTH           = 8,
    parameter int DIGITS          = 4,
    parameter int DEBOUNCE_CYCLES = 16,
    parameter int SCAN_DIV        = 4
) (
    input  logic              Clk,
    input  logic              reset,
    input  logic              pb_a,
    input  logic              pb_b,
    input  logic              pb_op,
    input  logic [WIDTH-1:0]  sw,
    output logic [WIDTH-1:0]  LED,
    output logic [3:0]        flags,
    output logic [DIGITS-1:0] AN_SEL,
    output logic [6:0]        seven_seg_out
);
    localparam int SW_W = (SCAN_DIV > 1) ? $clog2(SCAN_DIV) : 1;
    localparam int DG_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

    logic w_a_stb, w_b_stb, w_op_stb;

    pb_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_a (
        .i_clk(Clk), .i_reset(reset), .i_raw(pb_a), .o_strobe(w_a_stb));
    pb_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_b (
        .i_clk(Clk), .i_reset(reset), .i_raw(pb_b), .o_strobe(w_b_stb));
    pb_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_db_op (
        .i_clk(Clk), .i_reset(reset), .i_raw(pb_op), .o_strobe(w_op_stb));

    logic [WIDTH-1:0] r_a, r_b, r_res;
    logic [2:0]       r_op;
    logic [3:0]       r_flags;
    disp_sel_e        r_sel;

    logic [2:0]       w_op;
    logic [WIDTH:0]   w_sum, w_dif;
    logic [WIDTH-1:0] w_res;
    logic             w_c, w_v;

    // The opcode being latched this cycle is bypassed so the result lands one
    // cycle after the strobe.
    always_comb begin
        w_op  = w_op_stb ? sw[2:0] : r_op;
        w_sum = {1'b0, r_a} + {1'b0, r_b};
        w_dif = {1'b0, r_a} - {1'b0, r_b};
        w_res = '0;
        w_c   = 1'b0;
        w_v   = 1'b0;
        case (w_op)
            OP_ADD: begin
                w_res = w_sum[WIDTH-1:0];
                w_c   = w_sum[WIDTH];
                w_v   = (r_a[WIDTH-1] == r_b[WIDTH-1]) && (w_sum[WIDTH-1] != r_a[WIDTH-1]);
            end
            OP_SUB: begin
                w_res = w_dif[WIDTH-1:0];
                w_c   = w_dif[WIDTH];
                w_v   = (r_a[WIDTH-1] != r_b[WIDTH-1]) && (w_dif[WIDTH-1] != r_a[WIDTH-1]);
            end
            OP_AND: w_res = r_a & r_b;
            OP_OR:  w_res = r_a | r_b;
            OP_XOR: w_res = r_a ^ r_b;
            OP_SHL: {w_c, w_res} = {r_a, 1'b0};
            OP_SHR: begin
                w_res = {1'b0, r_a[WIDTH-1:1]};
                w_c   = r_a[0];
            end
            default: w_res = '0;
        endcase
    end

    always_ff @(posedge Clk) begin
        if (reset) begin
            r_a     <= '0;
            r_b     <= '0;
            r_op    <= OP_CLR;
            r_res   <= '0;
            r_flags <= '0;
            r_sel   <= SHOW_RES;
        end else if (w_a_stb) begin
            r_a   <= sw;
            r_sel <= SHOW_A;
        end else if (w_b_stb) begin
            r_b   <= sw;
            r_sel <= SHOW_B;
        end else if (w_op_stb) begin
            r_op    <= sw[2:0];
            r_res   <= w_res;
            r_flags <= {w_c, (w_res == '0), w_res[WIDTH-1], w_v};
            r_sel   <= SHOW_RES;
        end
    end

    assign LED   = r_res;
    assign flags = r_flags;

    logic [4*DIGITS-1:0] w_ext;
    logic [3:0]          w_nib;
    logic [DIGITS-1:0]   w_an;
    logic [SW_W-1:0]     r_scan;
    logic [DG_W-1:0]     r_dig;
    logic [DIGITS-1:0]   r_an;
    logic [6:0]          r_seg;

    always_comb begin
        w_ext = '0;
        case (r_sel)
            SHOW_A:  w_ext[WIDTH-1:0] = r_a;
            SHOW_B:  w_ext[WIDTH-1:0] = r_b;
            default: w_ext[WIDTH-1:0] = r_res;
        endcase
        w_nib = 4'h0;
        w_an  = '1;
        for (int i = 0; i < DIGITS; i++) begin
            if (r_dig == DG_W'(i)) begin
                w_nib   = w_ext[i*4 +: 4];
                w_an[i] = 1'b0;
            end
        end
    end

    // Anode and segments are both registered from r_dig, so they always agree.
    always_ff @(posedge Clk) begin
        if (reset) begin
            r_scan <= '0;
            r_dig  <= '0;
            r_an   <= '1;
            r_seg  <= 7'h7F;
        end else begin
            r_an  <= w_an;
            r_seg <= hex2seg(w_nib);
            if (r_scan == SW_W'(SCAN_DIV - 1)) begin
                r_scan <= '0;
                r_dig  <= (r_dig == DG_W'(DIGITS - 1)) ? '0 : r_dig + 1'b1;
            end else begin
                r_scan <= r_scan + 1'b1;
            end
        end
    end

    assign AN_SEL        = r_an;
    assign seven_seg_out = r_seg;

endmodule

// File: tb/tb_alu_top_param.sv
// Self-checking bench for alu_top_param: table of ALU vectors through the
// buttons, plus debounce, priority, hold, scan and reset sequences.
module tb_alu_top_param;
    localparam int W  = 8;
    localparam int DG = 4;
    localparam int D  = 16;
    localparam int SD = 4;

    logic          Clk = 1'b0, reset = 1'b1;
    logic          pb_a = 1'b0, pb_b = 1'b0, pb_op = 1'b0;
    logic [W-1:0]  sw = '0;
    logic [W-1:0]  LED;
    logic [3:0]    flags;
    logic [DG-1:0] AN_SEL;
    logic [6:0]    seven_seg_out;

    alu_top_param #(.WIDTH(W), .DIGITS(DG), .DEBOUNCE_CYCLES(D), .SCAN_DIV(SD)) dut (
        .Clk(Clk), .reset(reset), .pb_a(pb_a), .pb_b(pb_b), .pb_op(pb_op), .sw(sw),
        .LED(LED), .flags(flags), .AN_SEL(AN_SEL), .seven_seg_out(seven_seg_out));

    always #5 Clk = ~Clk;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [W-1:0]    led;
        logic [3:0]      flg;
        logic [4*DG-1:0] disp;
    } exp_t;
    exp_t sbq[$];

    typedef struct {
        logic [W-1:0] a, b, opsw, led;
        logic [3:0]   flg;   // {C,Z,N,V}
    } vec_t;
    vec_t vt[11];

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge Clk);
            #1;
        end
    endtask

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic logic [6:0] seg_of(input logic [3:0] n);
        logic [6:0] t[16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                              7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
        return t[n];
    endfunction

    function automatic logic [3:0] nib_of(input logic [6:0] s);
        for (int k = 0; k < 16; k++)
            if (seg_of(k[3:0]) == s) return k[3:0];
        return 4'bxxxx;
    endfunction

    // Watch two full scan rounds and rebuild the shown value digit by digit.
    task automatic chk_disp(input string nm, input logic [4*DG-1:0] exp);
        logic [4*DG-1:0] act;
        logic [DG-1:0]   m;
        act = 'x;
        for (int t = 0; t < 2 * DG * SD; t++) begin
            tick(1);
            for (int i = 0; i < DG; i++) begin
                m = '1;
                m[i] = 1'b0;
                if (AN_SEL == m) act[i*4 +: 4] = nib_of(seven_seg_out);
            end
        end
        chk(nm, act, exp);
    endtask

    task automatic press(input int btn, input logic [W-1:0] v, input int hold);
        sw = v;
        case (btn)
            0: pb_a = 1'b1;
            1: pb_b = 1'b1;
            default: pb_op = 1'b1;
        endcase
        tick(hold);
        pb_a = 1'b0; pb_b = 1'b0; pb_op = 1'b0;
        tick(D + 6);
    endtask

    task automatic sb_check(input string nm);
        exp_t e;
        checks++;
        if (sbq.size() == 0) begin
            errors++;
            $display("FAIL %s: scoreboard empty, got LED %0h", nm, LED);
        end else begin
            checks--;
            e = sbq.pop_front();
            chk({nm, "_led"}, LED, e.led);
            chk({nm, "_flags"}, flags, e.flg);
            chk_disp({nm, "_disp"}, e.disp);
        end
    endtask

    initial begin
        int n;
        logic [DG-1:0] m;

        vt[0]  = '{8'h0F, 8'h05, 8'h01, 8'h14, 4'b0000};
        vt[1]  = '{8'h05, 8'h0F, 8'h02, 8'hF6, 4'b1010};
        vt[2]  = '{8'h7F, 8'h01, 8'h01, 8'h80, 4'b0011};
        vt[3]  = '{8'hFF, 8'h01, 8'hF9, 8'h00, 4'b1100};
        vt[4]  = '{8'h80, 8'h01, 8'h02, 8'h7F, 4'b0001};
        vt[5]  = '{8'hF0, 8'h3C, 8'h03, 8'h30, 4'b0000};
        vt[6]  = '{8'hF0, 8'h0C, 8'h04, 8'hFC, 4'b0010};
        vt[7]  = '{8'hAA, 8'hAA, 8'h05, 8'h00, 4'b0100};
        vt[8]  = '{8'h81, 8'h00, 8'h06, 8'h02, 4'b1000};
        vt[9]  = '{8'h81, 8'h00, 8'h07, 8'h40, 4'b1000};
        vt[10] = '{8'h55, 8'hAA, 8'h00, 8'h00, 4'b0100};

        // Reset state
        reset = 1'b1;
        tick(25);
        chk("rst_led", LED, 0);
        chk("rst_flags", flags, 0);
        chk("rst_an", AN_SEL, 4'hF);
        chk("rst_seg", seven_seg_out, 7'h7F);

        // Scan order right after reset release, then reset mid-scan
        reset = 1'b0;
        for (int t = 0; t < 2 * DG * SD; t++) begin
            tick(1);
            m = '1;
            m[(t / SD) % DG] = 1'b0;
            chk("an_scan", AN_SEL, m);
        end
        tick(2);
        reset = 1'b1;
        tick(1);
        chk("midscan_rst_an", AN_SEL, 4'hF);
        chk("midscan_rst_seg", seven_seg_out, 7'h7F);
        tick(2);
        reset = 1'b0;
        chk_disp("disp_after_rst", 16'h0000);

        // First op with exact strobe latency measurement
        press(0, 8'h0F, 25);
        chk_disp("disp_a", 16'h000F);
        press(1, 8'h05, 25);
        chk_disp("disp_b", 16'h0005);
        sbq.push_back('{8'h14, 4'b0000, 16'h0014});
        sw = 8'h01;
        pb_op = 1'b1;
        n = 0;
        while (n < 100) begin
            tick(1);
            n++;
            if (LED == 8'h14) break;
        end
        chk("op_latency", n, D + 3);
        if (n < 25) tick(25 - n);
        pb_op = 1'b0;
        tick(D + 6);
        sb_check("first_add");

        // Table of ALU vectors
        foreach (vt[i]) begin
            press(0, vt[i].a, 25);
            press(1, vt[i].b, 25);
            sbq.push_back('{vt[i].led, vt[i].flg, {8'h00, vt[i].led}});
            press(2, vt[i].opsw, 25);
            sb_check($sformatf("vec%0d", i));
        end

        // Short pulse and bounce train must not load A (A=55, B=AA, result 00)
        sw = 8'h33;
        pb_a = 1'b1;
        tick(D - 1);
        pb_a = 1'b0;
        tick(D + 6);
        repeat (4) begin
            pb_a = 1'b1; tick(3);
            pb_a = 1'b0; tick(3);
        end
        tick(D + 6);
        chk_disp("bounce_disp", 16'h0000);
        sbq.push_back('{8'hFF, 4'b0010, 16'h00FF});
        press(2, 8'h01, 25);
        sb_check("bounce_add");

        // A and OP aligned: A wins, result untouched
        sw = 8'h05;
        pb_a = 1'b1; pb_op = 1'b1;
        tick(25);
        pb_a = 1'b0; pb_op = 1'b0;
        tick(D + 6);
        chk("simul_aop_led", LED, 8'hFF);
        chk("simul_aop_flags", flags, 4'b0010);
        chk_disp("simul_aop_disp", 16'h0005);

        // A and B aligned: A wins, B discarded
        sw = 8'h0A;
        pb_a = 1'b1; pb_b = 1'b1;
        tick(25);
        pb_a = 1'b0; pb_b = 1'b0;
        tick(D + 6);
        chk_disp("simul_ab_disp", 16'h000A);
        sbq.push_back('{8'hB4, 4'b0010, 16'h00B4});
        press(2, 8'h01, 25);
        sb_check("simul_ab_add");

        // Held OP strobes once; a new A does not recompute the result
        sw = 8'h02;
        pb_op = 1'b1;
        tick(30);
        chk("held_op_led", LED, 8'h60);
        chk("held_op_flags", flags, 4'b1000);
        sw = 8'h20;
        pb_a = 1'b1;
        tick(25);
        pb_a = 1'b0;
        tick(D + 20);
        chk("held_op_no_restrobe", LED, 8'h60);
        pb_op = 1'b0;
        tick(D + 6);
        chk("release_led", LED, 8'h60);
        chk_disp("release_disp", 16'h0020);

        // Button held across reset must re-qualify from scratch
        sw = 8'h22;
        pb_a = 1'b1;
        tick(10);
        reset = 1'b1;
        tick(2);
        reset = 1'b0;
        tick(10);
        pb_a = 1'b0;
        tick(D + 6);
        chk("held_rst_led", LED, 0);
        chk("held_rst_flags", flags, 0);
        chk_disp("held_rst_disp", 16'h0000);
        press(0, 8'h22, 25);
        chk_disp("requalify_disp", 16'h0022);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
